// File: rtl/addr_fetch_stage.sv
// Address fetch stage: accepts scan addresses, issues SRAM reads and buffers the
// returned data in a small credit-limited FIFO with a per-element frame-last flag.
module addr_fetch_stage #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   frame_len,
    input  logic [AW-1:0] addr_in,
    input  logic          addr_valid,
    output logic          addr_ready,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    input  logic          data_ready,
    output logic          data_last,
    output logic          busy,
    output logic          done
);
    localparam int CW = $clog2(DEPTH);
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [31:0]    len_q, issue_cnt, pop_cnt;
    logic [OW-1:0]  occ;
    logic [CW-1:0]  wr_ptr, rd_ptr;
    logic           inflight, last_p1;
    logic [AW-1:0]  addr_q;
    logic           done_zero;
    logic [DW-1:0]  fifo_data [DEPTH];
    logic           fifo_last [DEPTH];
    logic           accept, push, pop, issue_final, drain_done, frame_go;

    // Credit check uses registered occupancy only, so a pop never frees a slot
    // in the same cycle and the FIFO can absorb every outstanding read.
    assign addr_ready  = (state == RUN) && ((occ + {{CW{1'b0}}, inflight}) < FULL);
    assign accept      = addr_valid && addr_ready;
    assign issue_final = (issue_cnt == len_q - 32'd1);
    assign frame_go    = (state == IDLE) && start && (frame_len != 32'd0);
    assign mem_ren     = accept;
    assign mem_addr    = accept ? addr_in : addr_q;
    assign push        = inflight;
    assign data_valid  = (occ != '0);
    assign pop         = data_valid && data_ready;
    assign data_out    = fifo_data[rd_ptr];
    assign data_last   = data_valid && fifo_last[rd_ptr];
    assign busy        = (state != IDLE);
    assign drain_done  = (state == DRAIN) && (occ == '0) && !inflight && (pop_cnt == len_q);
    assign done        = drain_done || done_zero;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_go) state_nxt = RUN;
            RUN:     if (accept && issue_final) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            inflight  <= 1'b0;
            last_p1   <= 1'b0;
            addr_q    <= '0;
            done_zero <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_zero <= (state == IDLE) && start && (frame_len == 32'd0);
            if (frame_go) begin
                len_q     <= frame_len;
                issue_cnt <= '0;
                pop_cnt   <= '0;
            end else begin
                if (accept) issue_cnt <= issue_cnt + 32'd1;
                if (pop)    pop_cnt   <= pop_cnt + 32'd1;
            end
            // p1: read data returns from the SRAM one cycle after the read enable
            inflight <= accept;
            last_p1  <= accept && issue_final;
            if (accept) addr_q <= addr_in;
            if (push)   wr_ptr <= wr_ptr + CW'(1);
            if (pop)    rd_ptr <= rd_ptr + CW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_last[wr_ptr] <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && occ == FULL))
            else $error("addr_fetch_stage: FIFO overflow");
        end
    end
endmodule

// File: tb/tb_addr_fetch_stage.sv
// Bench for addr_fetch_stage: table of frame scenarios driven through a
// scoreboard, plus hand sequences for reset-mid-frame and timing corners.
module tb_addr_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] frame_len;
    logic [15:0] addr_in;
    logic        addr_valid;
    logic        addr_ready;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        data_last;
    logic        busy;
    logic        done;

    addr_fetch_stage #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .addr_in(addr_in), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .data_last(data_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, contents = address + 0x100
    always @(posedge clk) if (mem_ren) mem_rdata <= mem_addr + 16'h0100;

    typedef struct packed { logic [15:0] d; logic l; } exp_t;
    typedef struct {
        int          len;
        int          pv;
        int          pr;
        logic [15:0] base;
        int          stall;
        int          restart;
        int          exp_elems;
        int          exp_done;
    } vec_t;

    exp_t sb[$];
    int tests = 0, failed = 0;
    int cyc = 0, cur_len = 0, acc = 0, pops = 0, done_cnt = 0, ren_cnt = 0;
    int first_acc, first_pop, last_pop, done_cyc, stall_acc, frame_k;
    logic busy_seen, last_ardy, stall_ardy;
    logic hold_v = 1'b0, hold_l;
    logic [15:0] hold_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        last_ardy = addr_ready;
        if (busy) busy_seen = 1'b1;
        if (mem_ren) ren_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (hold_v) begin
            chk("stall_data_stable", data_out, hold_d);
            chk("stall_last_stable", data_last, hold_l);
        end
        if (addr_valid && addr_ready) begin
            chk("mem_ren_on_accept", mem_ren, 1'b1);
            chk("mem_addr_on_accept", mem_addr, addr_in);
            e.d = addr_in + 16'h0100;
            e.l = (acc == cur_len - 1);
            sb.push_back(e);
            if (acc == 0) first_acc = cyc;
            acc++;
        end
        if (data_valid && data_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {data_out, data_last}, 17'h0);
            end else begin
                e = sb.pop_front();
                chk("data_out", data_out, e.d);
                chk("data_last", data_last, e.l);
            end
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
        end
        hold_v = data_valid && !data_ready;
        hold_d = data_out;
        hold_l = data_last;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_addr_ready"}, addr_ready, 1'b0);
        chk({tag, "_mem_ren"}, mem_ren, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 16'h0);
        chk({tag, "_data_valid"}, data_valid, 1'b0);
        chk({tag, "_data_last"}, data_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int len, input int pv, input int pr, input logic [15:0] base,
                             input int stall, input int restart);
        int k;
        cur_len = len; acc = 0; pops = 0; done_cnt = 0; ren_cnt = 0;
        busy_seen = 1'b0; first_acc = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
        stall_acc = -1; stall_ardy = 1'bx;
        start = 1'b1; frame_len = len; addr_valid = 1'b0; data_ready = 1'b0;
        step();
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            addr_valid = (acc < len) && ($urandom_range(99) < pv);
            addr_in    = base + acc[15:0];
            data_ready = (k >= stall) && ($urandom_range(99) < pr);
            start      = (k == restart);
            frame_len  = start ? 32'd5 : len;
            step();
            if (k == stall - 1) begin stall_acc = acc; stall_ardy = last_ardy; end
            k++;
        end
        frame_k = k;
        start = 1'b0; addr_valid = 1'b0; data_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{len: 4,   pv: 100, pr: 100, base: 16'h0010, stall: 0, restart: -1, exp_elems: 4,   exp_done: 1};
        tbl[1] = '{len: 8,   pv: 100, pr: 100, base: 16'h0040, stall: 6, restart: -1, exp_elems: 8,   exp_done: 1};
        tbl[2] = '{len: 0,   pv: 100, pr: 100, base: 16'h0000, stall: 0, restart: -1, exp_elems: 0,   exp_done: 1};
        tbl[3] = '{len: 100, pv: 50,  pr: 50,  base: 16'h0200, stall: 0, restart: -1, exp_elems: 100, exp_done: 1};
        tbl[4] = '{len: 3,   pv: 100, pr: 50,  base: 16'h0300, stall: 0, restart: 1,  exp_elems: 3,   exp_done: 1};
        tbl[5] = '{len: 1,   pv: 100, pr: 100, base: 16'h0400, stall: 0, restart: -1, exp_elems: 1,   exp_done: 1};
        tbl[6] = '{len: 17,  pv: 70,  pr: 40,  base: 16'h0500, stall: 0, restart: -1, exp_elems: 17,  exp_done: 1};

        rst = 1'b1; start = 1'b0; frame_len = 32'd0; addr_in = 16'h0;
        addr_valid = 1'b0; data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("reset");

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].len, tbl[i].pv, tbl[i].pr, tbl[i].base, tbl[i].stall, tbl[i].restart);
            chk($sformatf("row%0d_no_timeout", i), frame_k < 3000, 1'b1);
            chk($sformatf("row%0d_delivered", i), pops, tbl[i].exp_elems);
            chk($sformatf("row%0d_done_count", i), done_cnt, tbl[i].exp_done);
            chk($sformatf("row%0d_queue_empty", i), sb.size(), 0);
            chk($sformatf("row%0d_idle_after", i), busy, 1'b0);
            if (i == 0) begin
                chk("latency_accept_to_valid", first_pop - first_acc, 2);
                chk("back_to_back_pops", last_pop - first_pop, 3);
                chk("done_after_last_pop", done_cyc - last_pop, 1);
            end
            if (i == 1) begin
                chk("credit_limited_accepts", stall_acc, 4);
                chk("addr_ready_low_when_full", stall_ardy, 1'b0);
            end
            if (i == 2) begin
                chk("zero_len_no_mem_ren", ren_cnt, 0);
                chk("zero_len_busy_never", busy_seen, 1'b0);
            end
            sb.delete();
        end

        // Reset with three elements buffered: nothing stale may leak into the next frame
        cur_len = 8; acc = 0; pops = 0;
        start = 1'b1; frame_len = 32'd8; addr_valid = 1'b0; data_ready = 1'b0;
        step();
        start = 1'b0;
        repeat (3) begin
            addr_valid = 1'b1;
            addr_in = 16'h0700 + acc[15:0];
            step();
        end
        addr_valid = 1'b0;
        repeat (2) step();
        chk("pre_rst_accepted", acc, 3);
        chk("pre_rst_buffered", data_valid, 1'b1);
        chk("pre_rst_no_pops", pops, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold_v = 1'b0;
        sb.delete();
        check_reset("midframe_reset");
        run_frame(2, 100, 100, 16'h0800, 0, -1);
        chk("after_rst_no_timeout", frame_k < 3000, 1'b1);
        chk("after_rst_delivered", pops, 2);
        chk("after_rst_done_count", done_cnt, 1);
        chk("after_rst_queue_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
